// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [1:0] EXT_WORD  = 2'b00;
  localparam logic [1:0] EXT_BYTEU = 2'b01;
  localparam logic [1:0] EXT_BYTES = 2'b10;
  localparam logic [1:0] EXT_HALFS = 2'b11;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      EXT_WORD:  return off != 2'b00;
      EXT_HALFS: return off[0];
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] sel, input logic [1:0] off);
    case (sel)
      EXT_WORD:  return BE_WORD;
      EXT_HALFS: return off[1] ? BE_HALF_HI : BE_HALF_LO;
      default:   return BE_BYTE << off;
    endcase
  endfunction

  // Replicate the store operand across every lane it may land in.
  function automatic logic [31:0] store_lanes(input logic [1:0] sel, input logic [31:0] d);
    case (sel)
      EXT_WORD:  return d;
      EXT_HALFS: return {2{d[15:0]}};
      default:   return {4{d[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half lane of a load word and sign/zero extends it.
module load_extender
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    off,
  input  logic [1:0]    sel,
  output logic [DW-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (sel)
      EXT_BYTEU: data = DW'(byte_v);
      EXT_BYTES: data = {{(DW-8){byte_v[7]}}, byte_v};
      EXT_HALFS: data = {{(DW-16){half_v[15]}}, half_v};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores on a req/ack port, stalls while outstanding,
// and registers the result and writeback controls for the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wmemi,
  input  logic          rmemi,
  input  logic          wregi,
  input  logic          wpci,
  input  logic [1:0]    jmpi,
  input  logic [3:0]    DestRi,
  input  logic [1:0]    ExtndSeli,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          stall_o,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wrego,
  output logic          wpco,
  output logic [1:0]    jmpo,
  output logic [3:0]    DestRo,
  output logic [DW-1:0] result_o,
  output logic          misalign_o,
  output logic          bus_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   lat_addr, lat_wdata, ext_data;
  logic            lat_we, lat_wreg, lat_wpc;
  logic [3:0]      lat_be, lat_dest;
  logic [1:0]      lat_sel, lat_jmp;

  logic access_c, misal_c, timeout_c, stall_c;
  logic start_c, pass_c, squash_c, done_c, abort_c;

  assign access_c  = wmemi | rmemi;
  assign misal_c   = access_c & is_misaligned(ExtndSeli, addr_i[1:0]);
  assign timeout_c = (cnt_q == CW'(TIMEOUT - 1));

  load_extender #(.DW(DW)) u_ext (
    .rdata (mem_rdata),
    .off   (lat_addr[1:0]),
    .sel   (lat_sel),
    .data  (ext_data)
  );

  // Next-state and stage-event decode.
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    start_c  = 1'b0;
    pass_c   = 1'b0;
    squash_c = 1'b0;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access_c) begin
          pass_c = 1'b1;
        end else if (misal_c) begin
          squash_c = 1'b1;
        end else begin
          stall_c = 1'b1;
          start_c = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (timeout_c) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port drive comes from latched values so it stays stable until ack.
  assign stall_o   = rst & stall_c;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & lat_we;
  assign mem_be    = mem_req ? lat_be : BE_NONE;
  assign mem_addr  = {lat_addr[DW-1:2], 2'b00};
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_be    <= BE_NONE;
      lat_sel   <= EXT_WORD;
      lat_wreg  <= 1'b0;
      lat_wpc   <= 1'b0;
      lat_jmp   <= '0;
      lat_dest  <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        cnt_q     <= '0;
        lat_addr  <= addr_i;
        lat_wdata <= DW'(store_lanes(ExtndSeli, wdata_i[31:0]));
        lat_we    <= wmemi;
        lat_be    <= byte_enables(ExtndSeli, addr_i[1:0]);
        lat_sel   <= ExtndSeli;
        lat_wreg  <= wregi;
        lat_wpc   <= wpci;
        lat_jmp   <= jmpi;
        lat_dest  <= DestRi;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // MEM/WB-facing output registers; they hold while an access is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrego      <= 1'b0;
      wpco       <= 1'b0;
      jmpo       <= '0;
      DestRo     <= '0;
      result_o   <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      misalign_o <= squash_c;
      bus_err_o  <= abort_c;
      if (pass_c) begin
        wrego    <= wregi;
        wpco     <= wpci;
        jmpo     <= jmpi;
        DestRo   <= DestRi;
        result_o <= addr_i;
      end else if (squash_c) begin
        wrego    <= 1'b0;
        wpco     <= 1'b0;
        jmpo     <= '0;
        DestRo   <= DestRi;
        result_o <= addr_i;
      end else if (done_c) begin
        wrego    <= lat_we ? 1'b0 : lat_wreg;
        wpco     <= lat_wpc;
        jmpo     <= lat_jmp;
        DestRo   <= lat_dest;
        result_o <= lat_we ? lat_addr : ext_data;
      end else if (abort_c) begin
        wrego    <= 1'b0;
        wpco     <= 1'b0;
        jmpo     <= '0;
        DestRo   <= lat_dest;
        result_o <= lat_addr;
      end
    end
  end

endmodule
